fifo_rd_drain: RTL

FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_rd_drain_if.sv | 48 ++++
 rtl/fifo_skid_buf.sv | 42 ++++
 rtl/fifo_rd_drain.sv | 88 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-drain block: default widths, output
// buffer depth and the drain state encoding.
package fifo_pkg;

  localparam int FIFO_WIDTH = 16;
  localparam int CNT_WIDTH  = 16;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drain_state_e;

endpackage

// File: rtl/fifo_rd_drain_if.sv
// Bundle of the FIFO-side and stream-side signals of the drain block.
// The master side is the drain block; the slave side is its environment.
interface fifo_rd_drain_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);

  logic                  enable;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic [FIFO_WIDTH-1:0] fifo_data_out;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic [CNT_WIDTH-1:0]  xfer_count;
  logic                  underflow_err;
  logic                  busy;

  modport master (
    input  enable,
    input  fifo_empty,
    input  fifo_underflow,
    input  fifo_data_out,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    input  m_ready,
    output xfer_count,
    output underflow_err,
    output busy
  );

  modport slave (
    output enable,
    output fifo_empty,
    output fifo_underflow,
    output fifo_data_out,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    output m_ready,
    input  xfer_count,
    input  underflow_err,
    input  busy
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer; push and pop may happen in the same cycle.
// The caller guarantees no push when full and no pop when empty.
module fifo_skid_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_popData,
  output logic [1:0]       o_count
);
  import fifo_pkg::*;

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (i_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_popData = r_mem[r_rdPtr];
  assign o_count   = r_count;

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains a synchronous-read FIFO into a valid/ready stream through a
// two-entry buffer, counting transfers and latching FIFO underflow.
module fifo_rd_drain #(
  parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int CNT_WIDTH  = fifo_pkg::CNT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  fifo_rd_drain_if.master  bus
);
  import fifo_pkg::*;

  drain_state_e          r_state;
  drain_state_e          w_nextState;
  logic                  r_inFlight;
  logic                  r_underflowErr;
  logic [CNT_WIDTH-1:0]  r_xferCount;
  logic                  w_rdEn;
  logic                  w_pop;
  logic                  w_bufValid;
  logic [1:0]            w_count;
  logic [2:0]            w_occupancy;
  logic [FIFO_WIDTH-1:0] w_bufData;

  fifo_skid_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_skidBuf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_inFlight),
    .i_pushData (bus.fifo_data_out),
    .i_pop      (w_pop),
    .o_popData  (w_bufData),
    .o_count    (w_count)
  );

  assign w_bufValid = (w_count != 2'd0);
  assign w_pop      = w_bufValid & bus.m_ready;

  // A new read is allowed only if the buffer can still absorb it after
  // the word already in flight lands, taking this cycle's pop into account.
  always_comb begin
    w_nextState = r_state;
    w_rdEn      = 1'b0;
    w_occupancy = {1'b0, w_count} + {2'b00, r_inFlight} - {2'b00, w_pop};
    case (r_state)
      IDLE: if (bus.enable) w_nextState = RUN;
      RUN:  if (!bus.enable) w_nextState = STOP;
      STOP: begin
        if (bus.enable) begin
          w_nextState = RUN;
        end else if (!r_inFlight && !w_bufValid) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if ((r_state == RUN) && !bus.fifo_empty && (w_occupancy < 3'd2)) begin
      w_rdEn = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_inFlight     <= 1'b0;
      r_xferCount    <= '0;
      r_underflowErr <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_inFlight <= w_rdEn;
      if (w_pop) begin
        r_xferCount <= r_xferCount + CNT_WIDTH'(1);
      end
      if (bus.fifo_underflow) begin
        r_underflowErr <= 1'b1;
      end
    end
  end

  assign bus.fifo_rd_en    = w_rdEn;
  assign bus.m_valid       = w_bufValid;
  assign bus.m_data        = w_bufData;
  assign bus.xfer_count    = r_xferCount;
  assign bus.underflow_err = r_underflowErr;
  assign bus.busy          = (r_state != IDLE) || w_bufValid || r_inFlight;

endmodule
